mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one external memory port between instruction fetch and execute-stage load/store.
- Sits between the core (pc/fetch and execute_instruction) and memory.
- Serialises requests with an ack handshake and produces the core-wide stall.
- Load/store has priority. A starvation guard guarantees fetch progress.

Parameters:
ADDR, 32, address width (shared with params.v)
W_DATA, 32, data width for both requesters and memory
STARVE_LIMIT, 4, consecutive LS grants allowed while fetch waits
TIMEOUT_CYC, 255, cycles in a grant state before err_o sets

Ports:
clk  in  1  clock (the only clock)
reset  in  1  synchronous, active-high reset
if_req_i  in  1  fetch request; held until if_ack_o
if_addr_i  in  ADDR  fetch address; stable while if_req_i
if_rdata_o  out  W_DATA  fetched word; valid when if_ack_o
if_ack_o  out  1  one-cycle completion pulse for fetch
ls_req_i  in  1  load/store request; held until ls_ack_o
ls_write_i  in  1  1 = store, 0 = load
ls_addr_i  in  ADDR  load/store address
ls_wdata_i  in  W_DATA  store data
ls_rdata_o  out  W_DATA  load data; valid when ls_ack_o
ls_ack_o  out  1  one-cycle completion pulse for load/store
mem_req_o  out  1  memory request; held until mem_ack_i
mem_we_o  out  1  memory write enable
mem_addr_o  out  ADDR  memory address
mem_wdata_o  out  W_DATA  memory write data
mem_rdata_i  in  W_DATA  memory read data; valid with mem_ack_i
mem_ack_i  in  1  memory completion, one cycle
stall_o  out  1  core stall
err_o  out  1  sticky timeout flag

Behaviour:
- Everything is on the rising edge of clk. On reset, or reset mid-transaction:
  - state = IDLE
  - mem_req_o, mem_we_o, if_ack_o, ls_ack_o, err_o = 0
  - mem_addr_o, mem_wdata_o, if_rdata_o, ls_rdata_o = 0
  - starve_cnt = 0, tmo_cnt = 0
  - the in-flight transaction is abandoned.
- FSM states: IDLE, GRANT_IF, GRANT_LS.
- IDLE arbitration, evaluated each cycle:
  - ls_req_i && !(if_req_i && starve_cnt == STARVE_LIMIT) -> GRANT_LS
  - else if_req_i -> GRANT_IF
  - else stay in IDLE.
- On entering a grant state, the same edge registers:
  - mem_req_o = 1
  - mem_addr_o = granted address
  - mem_we_o = ls_write_i for LS, 0 for IF
  - mem_wdata_o = ls_wdata_i for LS.
  - These hold constant until ack.
- Grant state with mem_ack_i = 1:
  - next cycle: mem_req_o = 0, mem_we_o = 0
  - matching *_ack_o = 1 for exactly one cycle
  - *_rdata_o = mem_rdata_i; it also updates for stores, but the value is don't-care
  - state -> IDLE.
- *_rdata_o holds its value until the next ack for that requester.
- Minimum latency: request seen in IDLE at cycle 0 -> mem_req_o at cycle 1 -> mem_ack_i at cycle 1 earliest -> *_ack_o at cycle 2.
  - There is always one IDLE cycle between transactions.
- The ack cycle itself is spent in IDLE. A requester may drop req on its ack cycle. A req still high in IDLE during its own ack cycle is not re-granted.
- starve_cnt:
  - +1 on each LS grant taken while if_req_i = 1, saturating at STARVE_LIMIT
  - cleared on any IF grant
  - cleared on an LS grant taken while if_req_i = 0.
- stall_o = (if_req_i & !if_ack_o) | (ls_req_i & !ls_ack_o). This is combinational.
- tmo_cnt:
  - counts cycles in a grant state without mem_ack_i
  - cleared on entry to a grant state
  - saturates.
- err_o:
  - set when tmo_cnt reaches TIMEOUT_CYC
  - cleared only by reset.
  - The FSM keeps waiting; there is no abort.
- A mem_ack_i arriving in IDLE is ignored: no ack pulse, no state change.
- Protocol errors (undefined; no checking required): dropping req before ack, or changing addr/data while pending.

Decomposition:
- ADDR and W_DATA come from the shared params.v.
- Add FSM state encodings (ARB_IDLE, ARB_GRANT_IF, ARB_GRANT_LS, width 2) to params.v.
- No sub-module. The saturating counters are inline.

Test Plan:
- Fetch only:
  - Stimulus: if_req_i = 1, if_addr_i = 0x100; memory acks 1 cycle after mem_req_o with rdata 0xDEADBEEF.
  - Response: mem_req_o = 1 at cycle 1 with addr 0x100 and we 0; if_ack_o pulses at cycle 3 with if_rdata_o = 0xDEADBEEF; stall_o = 1 during cycles 0-2.
- Simultaneous requests:
  - Stimulus: if_req_i and ls_req_i (store, addr 0x40, data 0x12345678) both rise at cycle 0.
  - Response: the LS store is granted first (mem_we_o = 1, addr 0x40, wdata 0x12345678); the fetch is granted after ls_ack_o plus one IDLE cycle.
- Starvation guard:
  - Stimulus: ls_req_i held high continuously for 6 transactions while if_req_i is held high.
  - Response: exactly 4 LS grants, then an IF grant, then LS resumes.
- Reset mid-grant:
  - Stimulus: assert reset for 1 cycle while in GRANT_LS with mem_req_o = 1; then assert mem_ack_i.
  - Response: mem_req_o = 0 the cycle after reset; no ls_ack_o; state is IDLE; the stale ack is ignored.
- Timeout:
  - Stimulus: with TIMEOUT_CYC = 8, never assert mem_ack_i.
  - Response: err_o = 1 after 8 grant cycles and stays 1; a later ack still completes normally with err_o remaining 1 until reset.
- Spurious ack:
  - Stimulus: pulse mem_ack_i while in IDLE with no requests.
  - Response: no *_ack_o pulse, stall_o = 0, no change to *_rdata_o.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared widths, defaults and FSM state encodings for the memory port arbiter.
// ADDR/W_DATA defaults mirror the core-wide parameter set.
package mem_port_arbiter_pkg;

  localparam int DEF_ADDR         = 32;
  localparam int DEF_W_DATA       = 32;
  localparam int DEF_STARVE_LIMIT = 4;
  localparam int DEF_TIMEOUT_CYC  = 255;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_GRANT_IF = 2'd1,
    ARB_GRANT_LS = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between instruction fetch and load/store.
// Load/store wins arbitration unless fetch has waited through STARVE_LIMIT LS grants.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR         = DEF_ADDR,
  parameter int W_DATA       = DEF_W_DATA,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int TIMEOUT_CYC  = DEF_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req_i,
  input  logic [ADDR-1:0]   if_addr_i,
  output logic [W_DATA-1:0] if_rdata_o,
  output logic              if_ack_o,
  input  logic              ls_req_i,
  input  logic              ls_write_i,
  input  logic [ADDR-1:0]   ls_addr_i,
  input  logic [W_DATA-1:0] ls_wdata_i,
  output logic [W_DATA-1:0] ls_rdata_o,
  output logic              ls_ack_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR-1:0]   mem_addr_o,
  output logic [W_DATA-1:0] mem_wdata_o,
  input  logic [W_DATA-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              stall_o,
  output logic              err_o
);

  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [SC_W-1:0]  SC_MAX  = SC_W'(STARVE_LIMIT);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYC);
  localparam logic [TMO_W-1:0] TMO_ERR = TMO_W'(TIMEOUT_CYC - 1);

  arb_state_e       state_r;
  logic [SC_W-1:0]  starve_cnt_r;
  logic [TMO_W-1:0] tmo_cnt_r;
  logic             arb_open_s;
  logic             starved_s;
  logic             grant_ls_s;
  logic             grant_if_s;

  // Arbitration decision; no grant is made during an ack cycle so a held request is not re-granted.
  always_comb begin
    grant_ls_s = 1'b0;
    grant_if_s = 1'b0;
    arb_open_s = (state_r == ARB_IDLE) && !if_ack_o && !ls_ack_o;
    starved_s  = if_req_i && (starve_cnt_r == SC_MAX);
    if (arb_open_s && ls_req_i && !starved_s) begin
      grant_ls_s = 1'b1;
    end else if (arb_open_s && if_req_i) begin
      grant_if_s = 1'b1;
    end else begin
      grant_ls_s = 1'b0;
      grant_if_s = 1'b0;
    end
  end

  // Core stall: a requester is stalled until its ack pulse is visible.
  assign stall_o = (if_req_i & ~if_ack_o) | (ls_req_i & ~ls_ack_o);

  // Arbiter FSM with registered memory-side and requester-side outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ARB_IDLE;
      mem_req_o    <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
      if_ack_o     <= 1'b0;
      ls_ack_o     <= 1'b0;
      if_rdata_o   <= '0;
      ls_rdata_o   <= '0;
      err_o        <= 1'b0;
      starve_cnt_r <= '0;
      tmo_cnt_r    <= '0;
    end else begin
      if_ack_o <= 1'b0;
      ls_ack_o <= 1'b0;
      case (state_r)
        ARB_IDLE: begin
          if (grant_ls_s) begin
            state_r     <= ARB_GRANT_LS;
            mem_req_o   <= 1'b1;
            mem_we_o    <= ls_write_i;
            mem_addr_o  <= ls_addr_i;
            mem_wdata_o <= ls_wdata_i;
            tmo_cnt_r   <= '0;
            // Only LS grants that bypass a waiting fetch count towards starvation.
            if (if_req_i) begin
              starve_cnt_r <= (starve_cnt_r == SC_MAX) ? SC_MAX : starve_cnt_r + SC_W'(1);
            end else begin
              starve_cnt_r <= '0;
            end
          end else if (grant_if_s) begin
            state_r      <= ARB_GRANT_IF;
            mem_req_o    <= 1'b1;
            mem_we_o     <= 1'b0;
            mem_addr_o   <= if_addr_i;
            tmo_cnt_r    <= '0;
            starve_cnt_r <= '0;
          end else begin
            state_r <= ARB_IDLE;
          end
        end
        ARB_GRANT_IF, ARB_GRANT_LS: begin
          if (mem_ack_i) begin
            state_r   <= ARB_IDLE;
            mem_req_o <= 1'b0;
            mem_we_o  <= 1'b0;
            if (state_r == ARB_GRANT_IF) begin
              if_ack_o   <= 1'b1;
              if_rdata_o <= mem_rdata_i;
            end else begin
              ls_ack_o   <= 1'b1;
              ls_rdata_o <= mem_rdata_i;
            end
          end else begin
            // Keep waiting forever; err_o only flags that the memory is overdue.
            if (tmo_cnt_r != TMO_MAX) begin
              tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
            end
            if (tmo_cnt_r >= TMO_ERR) begin
              err_o <= 1'b1;
            end
          end
        end
        default: begin
          state_r   <= ARB_IDLE;
          mem_req_o <= 1'b0;
          mem_we_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule
